// File: rtl/lane_car_engine.sv
// ---------------------------------------------------------------------------
// lane_car_engine
//   Drives one traffic lane of the frog game. A prescaler paces a car that
//   moves horizontally across a 640-px screen and wraps at the edges. The
//   block produces a registered per-pixel "car here" flag for the colour
//   mux, and a sticky collision flag against the frog.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous reset, active-high
//   enable         in   1 = lane runs; 0 = prescaler and car_x freeze
//   next_x/next_y  in   coordinates of the next pixel from the VGA driver
//   frog_row       in   current frog row (0..9)
//   frog_x         in   frog left edge (frog is 32 px wide)
//   collision_clr  in   one-cycle pulse clearing collision
//   car_x          out  current car left edge, 0..639
//   move_tick      out  one-cycle pulse on the cycle car_x updates
//   car_pixel      out  registered: (next_x,next_y) lies inside the car
//   collision      out  sticky: car and frog overlapped
// ---------------------------------------------------------------------------
module lane_car_engine #(
  parameter logic [3:0]  LANE_ROW = 4'd4,
  parameter logic [9:0]  CAR_W    = 10'd32,
  parameter logic [9:0]  STEP     = 10'd32,
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter logic        DIR      = 1'b0,
  parameter logic [9:0]  START_X  = 10'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic [3:0] frog_row,
  input  logic [9:0] frog_x,
  input  logic       collision_clr,
  output logic [9:0] car_x,
  output logic       move_tick,
  output logic       car_pixel,
  output logic       collision
);

  localparam int unsigned   CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0]   SCREEN_W = 11'd640;
  localparam logic [10:0]   ROW_LO   = 11'(48 * int'(LANE_ROW));
  localparam logic [10:0]   ROW_HI   = ROW_LO + 11'd48;
  localparam logic [10:0]   FROG_W   = 11'd32;

  logic [CW-1:0] r_cnt;
  logic [9:0]    r_car_x;
  logic          r_move_tick;
  logic          r_car_pixel;
  logic          r_collision;

  logic          w_tick;
  logic [10:0]   w_x;
  logic [10:0]   w_sum;
  logic [10:0]   w_next_pos;
  logic [10:0]   w_end;
  logic          w_wrap;
  logic [10:0]   w_a_end;
  logic [10:0]   w_b_end;
  logic [10:0]   w_px;
  logic [10:0]   w_py;
  logic [10:0]   w_fx;
  logic [10:0]   w_fx_end;
  logic          w_pix_hit;
  logic          w_overlap;

  assign w_tick = enable && (r_cnt == CNT_LAST);

  // Next car position, computed in 11 bits so the wrap compare cannot overflow.
  assign w_x   = {1'b0, r_car_x};
  assign w_sum = w_x + {1'b0, STEP};
  always_comb begin
    w_next_pos = w_x;
    if (DIR == 1'b0) begin
      w_next_pos = (w_sum >= SCREEN_W) ? (w_sum - SCREEN_W) : w_sum;
    end else begin
      w_next_pos = (w_x >= {1'b0, STEP}) ? (w_x - {1'b0, STEP})
                                         : (w_x + SCREEN_W - {1'b0, STEP});
    end
  end

  // Car occupies [car_x, a_end) plus, when it runs off the right edge,
  // [0, b_end). b_end is 0 when there is no wrapped part, which makes the
  // "< b_end" tests below naturally false.
  assign w_end   = w_x + {1'b0, CAR_W};
  assign w_wrap  = (w_end > SCREEN_W);
  assign w_a_end = w_wrap ? SCREEN_W : w_end;
  assign w_b_end = w_wrap ? (w_end - SCREEN_W) : 11'd0;

  assign w_px = {1'b0, next_x};
  assign w_py = {1'b0, next_y};
  // Row band never extends past 480, so it also rejects next_y >= 480.
  assign w_pix_hit = (w_py >= ROW_LO) && (w_py < ROW_HI) && (w_px < SCREEN_W) &&
                     (((w_px >= w_x) && (w_px < w_a_end)) || (w_px < w_b_end));

  // Half-open interval intersection: edges that only touch do not count.
  assign w_fx     = {1'b0, frog_x};
  assign w_fx_end = w_fx + FROG_W;
  assign w_overlap = (frog_row == LANE_ROW) &&
                     (((w_fx < w_a_end) && (w_x < w_fx_end)) || (w_fx < w_b_end));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_car_x     <= START_X;
      r_move_tick <= 1'b0;
      r_car_pixel <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_move_tick <= w_tick;
      if (enable) begin
        r_cnt <= w_tick ? '0 : (r_cnt + CW'(1));
      end
      if (w_tick) begin
        r_car_x <= w_next_pos[9:0];
      end
      r_car_pixel <= w_pix_hit;
      // Set has priority over clear.
      if (w_overlap) begin
        r_collision <= 1'b1;
      end else if (collision_clr) begin
        r_collision <= 1'b0;
      end
    end
  end

  assign car_x     = r_car_x;
  assign move_tick = r_move_tick;
  assign car_pixel = r_car_pixel;
  assign collision = r_collision;

endmodule

// File: tb/tb_lane_car_engine.sv
// ---------------------------------------------------------------------------
// tb_lane_car_engine
//   Directed bench for lane_car_engine. Several instances with different
//   parameter sets share the pixel/frog inputs; each scenario task drives
//   stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lane_car_engine;

  logic       clock;
  logic       reset;
  logic       en0;
  logic       en_w;
  logic       en_off;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [3:0] frog_row;
  logic [9:0] frog_x;
  logic       collision_clr;

  logic [9:0] x0, x1, x2, x3, x4;
  logic       t0, t1, t2, t3, t4;
  logic       p0, p1, p2, p3, p4;
  logic       c0, c1, c2, c3, c4;

  int total;
  int bad;

  // u0: motion / freeze / reset-mid-run
  lane_car_engine #(.LANE_ROW(4'd4), .CAR_W(10'd32), .STEP(10'd32), .TICK_DIV(4),
                    .DIR(1'b0), .START_X(10'd0)) u0 (
    .clock(clock), .reset(reset), .enable(en0), .next_x(next_x), .next_y(next_y),
    .frog_row(frog_row), .frog_x(frog_x), .collision_clr(collision_clr),
    .car_x(x0), .move_tick(t0), .car_pixel(p0), .collision(c0));

  // u1: right wrap
  lane_car_engine #(.LANE_ROW(4'd4), .CAR_W(10'd32), .STEP(10'd48), .TICK_DIV(4),
                    .DIR(1'b0), .START_X(10'd608)) u1 (
    .clock(clock), .reset(reset), .enable(en_w), .next_x(next_x), .next_y(next_y),
    .frog_row(frog_row), .frog_x(frog_x), .collision_clr(collision_clr),
    .car_x(x1), .move_tick(t1), .car_pixel(p1), .collision(c1));

  // u2: left wrap
  lane_car_engine #(.LANE_ROW(4'd4), .CAR_W(10'd32), .STEP(10'd48), .TICK_DIV(4),
                    .DIR(1'b1), .START_X(10'd16)) u2 (
    .clock(clock), .reset(reset), .enable(en_w), .next_x(next_x), .next_y(next_y),
    .frog_row(frog_row), .frog_x(frog_x), .collision_clr(collision_clr),
    .car_x(x2), .move_tick(t2), .car_pixel(p2), .collision(c2));

  // u3: stationary car at 624 (wraps), pixel tests
  lane_car_engine #(.LANE_ROW(4'd4), .CAR_W(10'd32), .STEP(10'd32), .TICK_DIV(4),
                    .DIR(1'b0), .START_X(10'd624)) u3 (
    .clock(clock), .reset(reset), .enable(en_off), .next_x(next_x), .next_y(next_y),
    .frog_row(frog_row), .frog_x(frog_x), .collision_clr(collision_clr),
    .car_x(x3), .move_tick(t3), .car_pixel(p3), .collision(c3));

  // u4: stationary car at 620, collision tests
  lane_car_engine #(.LANE_ROW(4'd4), .CAR_W(10'd32), .STEP(10'd32), .TICK_DIV(4),
                    .DIR(1'b0), .START_X(10'd620)) u4 (
    .clock(clock), .reset(reset), .enable(en_off), .next_x(next_x), .next_y(next_y),
    .frog_row(frog_row), .frog_x(frog_x), .collision_clr(collision_clr),
    .car_x(x4), .move_tick(t4), .car_pixel(p4), .collision(c4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    total++; if (x0 !== 10'd0) begin bad++; $display("FAIL reset_car_x: got %0d want 0", x0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL reset_collision: got %b want 0", c0); end
    total++; if (p0 !== 1'b0) begin bad++; $display("FAIL reset_car_pixel: got %b want 0", p0); end
    total++; if (t0 !== 1'b0) begin bad++; $display("FAIL reset_move_tick: got %b want 0", t0); end
    total++; if (x1 !== 10'd608) begin bad++; $display("FAIL reset_start_x_u1: got %0d want 608", x1); end
    reset = 1'b0;
    $display("reset: car_x=%0d collision=%b car_pixel=%b move_tick=%b", x0, c0, p0, t0);
  endtask

  task automatic test_motion();
    logic       exp_t;
    logic [9:0] exp_x;
    en0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_t = (i % 4 == 0);
      exp_x = 10'(32 * (i / 4));
      total++; if (t0 !== exp_t) begin bad++; $display("FAIL motion_tick cyc%0d: got %b want %b", i, t0, exp_t); end
      total++; if (x0 !== exp_x) begin bad++; $display("FAIL motion_car_x cyc%0d: got %0d want %0d", i, x0, exp_x); end
      $display("motion cyc%0d: move_tick=%b car_x=%0d", i, t0, x0);
    end
    en0 = 1'b0;
  endtask

  task automatic test_wrap();
    en_w = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    total++; if (x1 !== 10'd608) begin bad++; $display("FAIL wrap_pre_u1: got %0d want 608", x1); end
    step();
    total++; if (t1 !== 1'b1) begin bad++; $display("FAIL wrap_tick_u1: got %b want 1", t1); end
    total++; if (x1 !== 10'd16) begin bad++; $display("FAIL wrap_right: got %0d want 16", x1); end
    total++; if (x2 !== 10'd608) begin bad++; $display("FAIL wrap_left: got %0d want 608", x2); end
    $display("wrap: right car_x=%0d left car_x=%0d", x1, x2);
    en_w = 1'b0;
    step();
    total++; if (t1 !== 1'b0) begin bad++; $display("FAIL wrap_tick_width: got %b want 0", t1); end
  endtask

  task automatic test_pixel();
    logic [9:0] px [4];
    logic [9:0] py [4];
    logic       pe [4];
    px[0] = 10'd630; py[0] = 10'd200; pe[0] = 1'b1;
    px[1] = 10'd10;  py[1] = 10'd200; pe[1] = 1'b1;
    px[2] = 10'd20;  py[2] = 10'd200; pe[2] = 1'b0;
    px[3] = 10'd630; py[3] = 10'd250; pe[3] = 1'b0;
    total++; if (x3 !== 10'd624) begin bad++; $display("FAIL pixel_car_x: got %0d want 624", x3); end
    for (int i = 0; i < 4; i++) begin
      next_x = px[i];
      next_y = py[i];
      step();
      total++; if (p3 !== pe[i]) begin bad++; $display("FAIL pixel (%0d,%0d): got %b want %b", px[i], py[i], p3, pe[i]); end
      $display("pixel (%0d,%0d): car_pixel=%b", px[i], py[i], p3);
    end
    next_x = 10'd700;
    next_y = 10'd0;
  endtask

  task automatic test_collision();
    frog_row = 4'd4; frog_x = 10'd600;
    step();
    total++; if (c4 !== 1'b1) begin bad++; $display("FAIL coll_set: got %b want 1", c4); end
    frog_row = 4'd5;
    step();
    total++; if (c4 !== 1'b1) begin bad++; $display("FAIL coll_sticky: got %b want 1", c4); end
    collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    total++; if (c4 !== 1'b0) begin bad++; $display("FAIL coll_clear: got %b want 0", c4); end
    frog_row = 4'd4; collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    total++; if (c4 !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got %b want 1", c4); end
    frog_row = 4'd5; collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    frog_row = 4'd4; frog_x = 10'd588;
    step(); step();
    total++; if (c4 !== 1'b0) begin bad++; $display("FAIL coll_touch: got %b want 0", c4); end
    total++; if (c3 !== 1'b0) begin bad++; $display("FAIL coll_touch_u3: got %b want 0", c3); end
    frog_x = 10'd16;
    step();
    total++; if (c3 !== 1'b0) begin bad++; $display("FAIL coll_wrap_touch: got %b want 0", c3); end
    frog_x = 10'd5;
    step();
    total++; if (c3 !== 1'b1) begin bad++; $display("FAIL coll_wrap_part: got %b want 1", c3); end
    $display("collision: u4=%b u3=%b", c4, c3);
    frog_row = 4'd0; collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
  endtask

  task automatic test_freeze_reset();
    logic       exp_t;
    logic [9:0] exp_x;
    en0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++; if (t0 !== 1'b0) begin bad++; $display("FAIL freeze_tick cyc%0d: got %b want 0", i, t0); end
      total++; if (x0 !== 10'd64) begin bad++; $display("FAIL freeze_car_x cyc%0d: got %0d want 64", i, x0); end
    end
    $display("freeze: car_x=%0d", x0);
    en0 = 1'b1;
    step(); step();
    total++; if (x0 !== 10'd64) begin bad++; $display("FAIL pre_reset_car_x: got %0d want 64", x0); end
    reset = 1'b1;
    #1;
    total++; if (x0 !== 10'd0) begin bad++; $display("FAIL async_reset_car_x: got %0d want 0", x0); end
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_t = (i == 4);
      exp_x = (i == 4) ? 10'd32 : 10'd0;
      total++; if (t0 !== exp_t) begin bad++; $display("FAIL post_reset_tick cyc%0d: got %b want %b", i, t0, exp_t); end
      total++; if (x0 !== exp_x) begin bad++; $display("FAIL post_reset_car_x cyc%0d: got %0d want %0d", i, x0, exp_x); end
      $display("post-reset cyc%0d: move_tick=%b car_x=%0d", i, t0, x0);
    end
    en0 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    en0 = 1'b0;
    en_w = 1'b0;
    en_off = 1'b0;
    next_x = 10'd700;
    next_y = 10'd0;
    frog_row = 4'd0;
    frog_x = 10'd0;
    collision_clr = 1'b0;

    test_reset();
    test_motion();
    test_wrap();
    test_pixel();
    test_collision();
    test_freeze_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
